// File: rtl/ball_pkg.sv
// Shared types and helpers for the per-ball velocity updater.
// Speeds are 11-bit two's complement. Arithmetic is done at 14 bits, which
// holds the sum of up to eight full-range sources without wrapping.
package ball_pkg;

  localparam int SPEED_W        = 11;
  localparam int SUM_W          = 14;
  localparam int MAX_BALL_SPEED = 20;

  typedef enum logic [1:0] {
    REST    = 2'd0,
    MOVING  = 2'd1,
    HOLDOFF = 2'd2
  } ball_state_e;

  // Sign-extend an 11-bit speed to the arithmetic width.
  function automatic logic signed [SUM_W-1:0] sext_speed(input logic [SPEED_W-1:0] v);
    return SUM_W'(signed'(v));
  endfunction

  // Saturate any value that fits the arithmetic width to +/-max_mag.
  // Narrower inputs are sign-extended by the caller, so this covers every width in use.
  function automatic logic signed [SPEED_W-1:0] sat_speed(input logic signed [SUM_W-1:0] v,
                                                          input int max_mag);
    logic signed [SUM_W-1:0] hi;
    hi = SUM_W'(max_mag);
    if (v > hi)       return SPEED_W'(hi);
    else if (v < -hi) return SPEED_W'(-hi);
    return SPEED_W'(v);
  endfunction

endpackage

// File: rtl/speed_clamp.sv
// Combinational saturator for one speed component.
module speed_clamp
  import ball_pkg::*;
#(
  parameter int MAX_SPEED = 20
) (
  input  logic signed [SUM_W-1:0]   raw_i,
  output logic signed [SPEED_W-1:0] clamped_o
);

  assign clamped_o = sat_speed(raw_i, MAX_SPEED);

endmodule

// File: rtl/ball_velocity_updater.sv
// Authoritative x/y speed of one ball. Each frame (vsync edge) one update is
// chosen: cue strike, then an accepted collision report, then friction decay.
// The chosen speed is clamped and registered together with ack/drop pulses.
// Optional: define COLLISION_SUM_EN to sum all simultaneous collision reports
// instead of taking the lowest-index one.
module ball_velocity_updater
  import ball_pkg::*;
#(
  parameter int NUM_SRC        = 3,
  parameter int MAX_BALL_SPEED = 20,
  parameter int HOLDOFF_FRAMES = 5,
  parameter int STOP_FRAMES    = 2
) (
  input  logic                       vsync,
  input  logic                       reset_n,
  input  logic [NUM_SRC-1:0]         collided,
  input  logic [SPEED_W*NUM_SRC-1:0] coll_xspeed,
  input  logic [SPEED_W*NUM_SRC-1:0] coll_yspeed,
  input  logic                       cue_hit,
  input  logic [SPEED_W-1:0]         cue_xspeed,
  input  logic [SPEED_W-1:0]         cue_yspeed,
  input  logic [SPEED_W-1:0]         fric_xspeed,
  input  logic [SPEED_W-1:0]         fric_yspeed,
  output logic [SPEED_W-1:0]         xspeed,
  output logic [SPEED_W-1:0]         yspeed,
  output logic                       moving,
  output logic [NUM_SRC-1:0]         coll_ack,
  output logic                       coll_dropped
);

  localparam int HW = $clog2(HOLDOFF_FRAMES) + 1;
  localparam int ZW = $clog2(STOP_FRAMES) + 1;

  logic [NUM_SRC-1:0][SPEED_W-1:0] cx, cy;
  assign cx = coll_xspeed;
  assign cy = coll_yspeed;

  ball_state_e               state_q;
  logic [HW-1:0]             hold_q;
  logic [ZW-1:0]             zcnt_q;
  logic [SPEED_W-1:0]        xs_q, ys_q;
  logic [NUM_SRC-1:0]        ack_q, ack_d;
  logic                      drop_q, drop_d;

  logic signed [SUM_W-1:0]   raw_x, raw_y;
  logic signed [SPEED_W-1:0] clx, cly;
  logic                      take_coll;
  logic                      found;
  logic                      spd_zero;

  // Pick this frame's raw speed and the ack/drop pulses that go with it.
  always_comb begin
    raw_x     = '0;
    raw_y     = '0;
    ack_d     = '0;
    drop_d    = 1'b0;
    take_coll = 1'b0;
    found     = 1'b0;
    if (cue_hit) begin
      raw_x  = sext_speed(cue_xspeed);
      raw_y  = sext_speed(cue_yspeed);
      drop_d = |collided;
    end else if (|collided && state_q != HOLDOFF) begin
      take_coll = 1'b1;
`ifdef COLLISION_SUM_EN
      for (int i = 0; i < NUM_SRC; i++) begin
        if (collided[i]) begin
          raw_x = raw_x + sext_speed(cx[i]);
          raw_y = raw_y + sext_speed(cy[i]);
        end
      end
      ack_d = collided;
`else
      for (int i = 0; i < NUM_SRC; i++) begin
        if (collided[i] && !found) begin
          found    = 1'b1;
          raw_x    = sext_speed(cx[i]);
          raw_y    = sext_speed(cy[i]);
          ack_d[i] = 1'b1;
        end
      end
      drop_d = |(collided & ~ack_d);
`endif
    end else begin
      // Reports arriving during holdoff land here and are discarded.
      drop_d = |collided;
      if (state_q != REST) begin
        raw_x = sext_speed(fric_xspeed);
        raw_y = sext_speed(fric_yspeed);
      end
    end
  end

  speed_clamp #(.MAX_SPEED(MAX_BALL_SPEED)) u_clamp_x (.raw_i(raw_x), .clamped_o(clx));
  speed_clamp #(.MAX_SPEED(MAX_BALL_SPEED)) u_clamp_y (.raw_i(raw_y), .clamped_o(cly));

  assign spd_zero = (clx == '0) && (cly == '0);

  // Motion FSM plus registered speed and pulse outputs.
  // Holdoff is entered with HOLDOFF_FRAMES-1 and left on the frame the count
  // would reach zero, so the window spans HOLDOFF_FRAMES frames counting the
  // accepting frame itself.
  always_ff @(posedge vsync or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= REST;
      hold_q  <= '0;
      zcnt_q  <= '0;
      xs_q    <= '0;
      ys_q    <= '0;
      ack_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      xs_q   <= clx;
      ys_q   <= cly;
      ack_q  <= ack_d;
      drop_q <= drop_d;
      if (cue_hit) begin
        state_q <= MOVING;
        hold_q  <= '0;
        zcnt_q  <= '0;
      end else if (take_coll) begin
        zcnt_q <= '0;
        // A zero-speed hit on a resting ball is acked but does not wake it.
        if (!(state_q == REST && spd_zero)) begin
          state_q <= HOLDOFF;
          hold_q  <= HW'(HOLDOFF_FRAMES - 1);
        end
      end else begin
        case (state_q)
          MOVING: begin
            if (spd_zero) begin
              if (zcnt_q >= ZW'(STOP_FRAMES - 1)) begin
                state_q <= REST;
                zcnt_q  <= '0;
              end else begin
                zcnt_q <= zcnt_q + ZW'(1);
              end
            end else begin
              zcnt_q <= '0;
            end
          end
          HOLDOFF: begin
            if (hold_q <= HW'(1)) begin
              hold_q  <= '0;
              state_q <= spd_zero ? REST : MOVING;
            end else begin
              hold_q <= hold_q - HW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign xspeed       = xs_q;
  assign yspeed       = ys_q;
  assign moving       = (state_q != REST);
  assign coll_ack     = ack_q;
  assign coll_dropped = drop_q;

endmodule

// File: tb/tb_ball_velocity_updater.sv
// Bench for ball_velocity_updater: directed frame table, reset-in-holdoff
// sequence, and randomized frames checked against a frame-level model.
module tb_ball_velocity_updater;

  localparam int NS = 3;
  localparam int HF = 5;
  localparam int SF = 2;
  localparam int MX = 20;

  logic            vsync = 1'b0;
  logic            reset_n = 1'b0;
  logic [NS-1:0]   collided;
  logic [11*NS-1:0] coll_xspeed, coll_yspeed;
  logic            cue_hit;
  logic [10:0]     cue_xspeed, cue_yspeed, fric_xspeed, fric_yspeed;
  logic [10:0]     xspeed, yspeed;
  logic            moving;
  logic [NS-1:0]   coll_ack;
  logic            coll_dropped;

  ball_velocity_updater #(
    .NUM_SRC(NS), .MAX_BALL_SPEED(MX), .HOLDOFF_FRAMES(HF), .STOP_FRAMES(SF)
  ) dut (
    .vsync(vsync), .reset_n(reset_n), .collided(collided),
    .coll_xspeed(coll_xspeed), .coll_yspeed(coll_yspeed),
    .cue_hit(cue_hit), .cue_xspeed(cue_xspeed), .cue_yspeed(cue_yspeed),
    .fric_xspeed(fric_xspeed), .fric_yspeed(fric_yspeed),
    .xspeed(xspeed), .yspeed(yspeed), .moving(moving),
    .coll_ack(coll_ack), .coll_dropped(coll_dropped)
  );

  always #5 vsync = ~vsync;

  int n_tests = 0;
  int n_fail  = 0;

  // Current frame inputs, as plain integers.
  bit       i_cue;
  int       i_cx, i_cy, i_fx, i_fy;
  int       i_sx[NS];
  int       i_sy[NS];
  bit [2:0] i_col;

  typedef struct {
    bit cue; int cx; int cy; bit [2:0] col;
    int s0x; int s0y; int s1x; int s1y; int s2x; int s2y;
    int fx; int fy;
    int ex; int ey; bit emov; bit [2:0] eack; bit edrop;
  } vec_t;

  function automatic vec_t mk(bit cue, int cx, int cy, bit [2:0] col,
                              int s0x, int s0y, int s1x, int s1y, int s2x, int s2y,
                              int fx, int fy, int ex, int ey, bit emov, bit [2:0] eack, bit edrop);
    vec_t v;
    v.cue = cue; v.cx = cx; v.cy = cy; v.col = col;
    v.s0x = s0x; v.s0y = s0y; v.s1x = s1x; v.s1y = s1y; v.s2x = s2x; v.s2y = s2y;
    v.fx = fx; v.fy = fy; v.ex = ex; v.ey = ey; v.emov = emov; v.eack = eack; v.edrop = edrop;
    return v;
  endfunction

  task automatic apply();
    cue_hit     = i_cue;
    cue_xspeed  = 11'(i_cx);
    cue_yspeed  = 11'(i_cy);
    fric_xspeed = 11'(i_fx);
    fric_yspeed = 11'(i_fy);
    collided    = i_col;
    for (int k = 0; k < NS; k++) begin
      coll_xspeed[11*k +: 11] = 11'(i_sx[k]);
      coll_yspeed[11*k +: 11] = 11'(i_sy[k]);
    end
  endtask

  task automatic clear_inputs();
    i_cue = 0; i_cx = 0; i_cy = 0; i_fx = 0; i_fy = 0; i_col = '0;
    for (int k = 0; k < NS; k++) begin i_sx[k] = 0; i_sy[k] = 0; end
    apply();
  endtask

  task automatic check(string name, int ex, int ey, bit emov, bit [2:0] eack, bit edrop);
    int ax, ay;
    ax = int'($signed(xspeed));
    ay = int'($signed(yspeed));
    n_tests++;
    if (ax !== ex || ay !== ey || moving !== emov || coll_ack !== eack || coll_dropped !== edrop) begin
      n_fail++;
      $display("FAIL %s: got x=%0d y=%0d mov=%0b ack=%b drop=%0b, want x=%0d y=%0d mov=%0b ack=%b drop=%0b",
               name, ax, ay, moving, coll_ack, coll_dropped, ex, ey, emov, eack, edrop);
    end
  endtask

  // Called at a negedge with inputs applied: advance one frame, land on the next negedge.
  task automatic tick();
    @(posedge vsync);
    @(negedge vsync);
  endtask

  // ---------------- frame-level reference model ----------------
  int       m_x, m_y, m_open, m_zrun, m_frame;
  bit       m_mov, m_hold, m_drop;
  bit [2:0] m_ack;

  function automatic int clampi(int v);
    if (v > MX) return MX;
    if (v < -MX) return -MX;
    return v;
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_open = 0; m_zrun = 0; m_frame = 0;
    m_mov = 0; m_hold = 0; m_drop = 0; m_ack = '0;
  endtask

  task automatic model_step();
    int  sx, sy;
    bit  any;
    m_frame++;
    any    = (i_col != 0);
    m_ack  = '0;
    m_drop = 0;
    if (i_cue) begin
      m_x = clampi(i_cx); m_y = clampi(i_cy);
      m_drop = any; m_mov = 1; m_hold = 0; m_zrun = 0;
    end else if (any && !m_hold) begin
      sx = 0; sy = 0;
`ifdef COLLISION_SUM_EN
      for (int k = 0; k < NS; k++)
        if (i_col[k]) begin sx += i_sx[k]; sy += i_sy[k]; end
      m_ack = i_col;
`else
      for (int k = NS - 1; k >= 0; k--)
        if (i_col[k]) begin sx = i_sx[k]; sy = i_sy[k]; m_ack = 3'(1 << k); end
      m_drop = ((i_col & ~m_ack) != 0);
`endif
      m_x = clampi(sx); m_y = clampi(sy);
      m_zrun = 0;
      if (m_mov || m_x != 0 || m_y != 0) begin
        m_mov = 1; m_hold = 1; m_open = m_frame + HF;
      end
    end else begin
      m_drop = any;
      if (m_mov) begin m_x = clampi(i_fx); m_y = clampi(i_fy); end
      else begin m_x = 0; m_y = 0; end
      if (m_hold) begin
        if (m_frame >= m_open - 1) begin
          m_hold = 0;
          if (m_x == 0 && m_y == 0) m_mov = 0;
        end
      end else if (m_mov) begin
        if (m_x == 0 && m_y == 0) begin
          m_zrun++;
          if (m_zrun >= SF) begin m_mov = 0; m_zrun = 0; end
        end else m_zrun = 0;
      end
    end
  endtask

  function automatic int rnd_speed();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 2047)) - 1024;
    return int'($urandom_range(0, 50)) - 25;
  endfunction

  vec_t tbl[$];

  initial begin
    // Directed frames, applied in order straight after the idle phase.
    tbl.push_back(mk(1, 15, -7, 3'b000, 0,0,0,0,0,0, 0,0,     15, -7, 1, 3'b000, 0));
    tbl.push_back(mk(0, 0, 0, 3'b000, 0,0,0,0,0,0, 14,-6,     14, -6, 1, 3'b000, 0));
`ifdef COLLISION_SUM_EN
    tbl.push_back(mk(0, 0, 0, 3'b110, 0,0,30,-40,5,5, 1,1,    20,-20, 1, 3'b110, 0));
`else
    tbl.push_back(mk(0, 0, 0, 3'b110, 0,0,30,-40,5,5, 1,1,    20,-20, 1, 3'b010, 1));
`endif
    tbl.push_back(mk(0, 0, 0, 3'b000, 0,0,0,0,0,0, 19,-19,    19,-19, 1, 3'b000, 0));
    tbl.push_back(mk(0, 0, 0, 3'b010, 0,0,3,3,0,0, 18,-18,    18,-18, 1, 3'b000, 1));
    tbl.push_back(mk(0, 0, 0, 3'b000, 0,0,0,0,0,0, 17,-17,    17,-17, 1, 3'b000, 0));
    tbl.push_back(mk(0, 0, 0, 3'b001, 1,1,0,0,0,0, 16,-16,    16,-16, 1, 3'b000, 1));
    tbl.push_back(mk(0, 0, 0, 3'b001, -1024,1023,0,0,0,0, 5,5, -20,20, 1, 3'b001, 0));
    tbl.push_back(mk(1, 2, 3, 3'b001, 9,9,0,0,0,0, 0,0,        2,  3, 1, 3'b000, 1));
    tbl.push_back(mk(0, 0, 0, 3'b001, 4,4,0,0,0,0, 0,0,        4,  4, 1, 3'b001, 0));
    tbl.push_back(mk(0, 0, 0, 3'b000, 0,0,0,0,0,0, 0,0,        0,  0, 1, 3'b000, 0));
    tbl.push_back(mk(0, 0, 0, 3'b000, 0,0,0,0,0,0, 0,0,        0,  0, 1, 3'b000, 0));
    tbl.push_back(mk(0, 0, 0, 3'b000, 0,0,0,0,0,0, 0,0,        0,  0, 1, 3'b000, 0));
    tbl.push_back(mk(0, 0, 0, 3'b000, 0,0,0,0,0,0, 0,0,        0,  0, 0, 3'b000, 0));
    tbl.push_back(mk(0, 0, 0, 3'b001, 0,0,0,0,0,0, 7,7,        0,  0, 0, 3'b001, 0));
    tbl.push_back(mk(0, 0, 0, 3'b100, 0,0,0,0,0,5, 0,0,        0,  5, 1, 3'b100, 0));
    tbl.push_back(mk(1, -30, 25, 3'b000, 0,0,0,0,0,0, 0,0,   -20, 20, 1, 3'b000, 0));
    tbl.push_back(mk(0, 0, 0, 3'b000, 0,0,0,0,0,0, 0,0,        0,  0, 1, 3'b000, 0));
    tbl.push_back(mk(0, 0, 0, 3'b000, 0,0,0,0,0,0, 0,0,        0,  0, 0, 3'b000, 0));
    tbl.push_back(mk(0, 0, 0, 3'b000, 0,0,0,0,0,0, 3,3,        0,  0, 0, 3'b000, 0));
`ifdef COLLISION_SUM_EN
    tbl.push_back(mk(0, 0, 0, 3'b011, 12,3,10,-1,0,0, 0,0,    20,  2, 1, 3'b011, 0));
`else
    tbl.push_back(mk(0, 0, 0, 3'b011, 12,3,10,-1,0,0, 0,0,    12,  3, 1, 3'b001, 1));
`endif
    tbl.push_back(mk(0, 0, 0, 3'b000, 0,0,0,0,0,0, 300,-300,  20,-20, 1, 3'b000, 0));
    tbl.push_back(mk(1, -1024, 0, 3'b000, 0,0,0,0,0,0, 0,0,  -20,  0, 1, 3'b000, 0));

    // Reset state.
    clear_inputs();
    repeat (2) @(negedge vsync);
    check("reset", 0, 0, 0, 3'b000, 0);
    reset_n = 1'b1;

    // Idle at rest: friction input must not move a resting ball.
    i_fx = 7; i_fy = 7; apply();
    for (int f = 0; f < 10; f++) begin
      tick();
      check("idle", 0, 0, 0, 3'b000, 0);
    end

    // Directed table.
    foreach (tbl[r]) begin
      i_cue = tbl[r].cue; i_cx = tbl[r].cx; i_cy = tbl[r].cy; i_col = tbl[r].col;
      i_sx[0] = tbl[r].s0x; i_sy[0] = tbl[r].s0y;
      i_sx[1] = tbl[r].s1x; i_sy[1] = tbl[r].s1y;
      i_sx[2] = tbl[r].s2x; i_sy[2] = tbl[r].s2y;
      i_fx = tbl[r].fx; i_fy = tbl[r].fy;
      apply();
      tick();
      check($sformatf("tbl%0d", r), tbl[r].ex, tbl[r].ey, tbl[r].emov, tbl[r].eack, tbl[r].edrop);
    end

    // Reset asserted mid-holdoff, then a collision must be accepted at once.
    clear_inputs();
    i_col = 3'b001; i_sx[0] = 8; i_sy[0] = 8; apply();
    tick();
    check("hold_enter", 8, 8, 1, 3'b001, 0);
    clear_inputs();
    i_fx = 6; i_fy = 6; i_col = 3'b010; i_sx[1] = 9; i_sy[1] = 9; apply();
    tick();
    check("hold_drop", 6, 6, 1, 3'b000, 1);
    clear_inputs();
    i_col = 3'b001; i_sx[0] = 3; apply();
    reset_n = 1'b0;
    #1;
    check("rst_mid_hold", 0, 0, 0, 3'b000, 0);
    #2;
    reset_n = 1'b1;
    clear_inputs();
    i_col = 3'b010; i_sx[1] = 6; i_sy[1] = -6; apply();
    tick();
    check("post_rst_coll", 6, -6, 1, 3'b010, 0);

    // Randomized frames against the model, from a fresh reset.
    clear_inputs();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    model_reset();
    @(negedge vsync);
    for (int f = 0; f < 400; f++) begin
      i_cue = ($urandom_range(0, 15) == 0);
      i_cx = rnd_speed(); i_cy = rnd_speed();
      i_col = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      for (int k = 0; k < NS; k++) begin i_sx[k] = rnd_speed(); i_sy[k] = rnd_speed(); end
      if ($urandom_range(0, 2) == 0) begin i_fx = 0; i_fy = 0; end
      else begin i_fx = rnd_speed(); i_fy = rnd_speed(); end
      apply();
      model_step();
      tick();
      check($sformatf("rand%0d", f), m_x, m_y, m_mov, m_ack, m_drop);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
